// File: rtl/cnn_accel_layer_seq_if.sv
// Control bundle between the host/frame engine and the CNN layer sequencer.
// The sequencer uses the slave modport; the host/engine side uses master.
interface cnn_accel_layer_seq_if #(
    parameter int unsigned NUM_LAYERS_MAX = 8
);
    localparam int unsigned NW = $clog2(NUM_LAYERS_MAX + 1);
    localparam int unsigned LW = (NUM_LAYERS_MAX > 1) ? $clog2(NUM_LAYERS_MAX) : 1;

    logic          start;
    logic [NW-1:0] num_layers;
    logic          abort;
    logic          eng_done;
    logic          eng_reset_n;
    logic          rd_bank;
    logic          wr_bank;
    logic [LW-1:0] layer_idx;
    logic          host_sel;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output start, num_layers, abort, eng_done,
        input  eng_reset_n, rd_bank, wr_bank, layer_idx, host_sel, busy, done, err
    );

    modport slave (
        input  start, num_layers, abort, eng_done,
        output eng_reset_n, rd_bank, wr_bank, layer_idx, host_sel, busy, done, err
    );
endinterface

// File: rtl/cnn_accel_layer_seq.sv
// Layer sequencer: runs the frame engine once per layer, ping-ponging the two frame banks
// and holding the engine in reset between layers. All outputs are registered.
module cnn_accel_layer_seq #(
    parameter int unsigned NUM_LAYERS_MAX = 8,
    parameter int unsigned WIDTH          = 320,
    parameter int unsigned HEIGHT         = 240,
    parameter int unsigned TIMEOUT_CYCLES = 80000
) (
    input logic                  clk,
    input logic                  reset_n,
    cnn_accel_layer_seq_if.slave bus
);
    localparam int unsigned NW         = $clog2(NUM_LAYERS_MAX + 1);
    localparam int unsigned LW         = (NUM_LAYERS_MAX > 1) ? $clog2(NUM_LAYERS_MAX) : 1;
    localparam int unsigned WDW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned MinTimeout = HEIGHT * (WIDTH + 1) + 2;

    // A watchdog shorter than one full frame would kill every healthy layer.
    if (TIMEOUT_CYCLES <= MinTimeout) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must exceed HEIGHT*(WIDTH+1)+2");
    end

    localparam logic [WDW-1:0] WdogLast = WDW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StRun,
        StDrain,
        StSwap,
        StFinish
    } state_e;

    state_e        r_state;
    state_e        w_state_next;
    logic          w_accept;
    logic          w_zero_start;
    logic          w_wd_expire;
    logic          w_swap;
    logic          w_more;
    logic [NW-1:0] w_num_sat;

    logic [NW-1:0]  r_num_layers;
    logic [LW-1:0]  r_layer_idx;
    logic [WDW-1:0] r_wdog;
    logic           r_rd_bank;
    logic           r_wr_bank;
    logic           r_eng_run;
    logic           r_host_sel;
    logic           r_busy;
    logic           r_done;
    logic           r_err;

    assign w_num_sat = (bus.num_layers > NW'(NUM_LAYERS_MAX)) ? NW'(NUM_LAYERS_MAX)
                                                               : bus.num_layers;
    assign w_more    = (NW'(r_layer_idx) + NW'(1)) < r_num_layers;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_zero_start = 1'b0;
        w_wd_expire  = 1'b0;
        w_swap       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    if (bus.num_layers != '0) begin
                        w_state_next = StLaunch;
                        w_accept     = 1'b1;
                    end else begin
                        w_zero_start = 1'b1;
                    end
                end
            end
            StLaunch: w_state_next = bus.abort ? StFinish : StRun;
            StRun: begin
                // abort > eng_done > watchdog
                if (bus.abort) begin
                    w_state_next = StFinish;
                end else if (bus.eng_done) begin
                    w_state_next = StDrain;
                end else if (r_wdog == WdogLast) begin
                    w_state_next = StFinish;
                    w_wd_expire  = 1'b1;
                end
            end
            StDrain: begin
                if (bus.abort || !w_more) begin
                    w_state_next = StFinish;
                end else begin
                    w_state_next = StSwap;
                end
            end
            StSwap: begin
                if (bus.abort) begin
                    w_state_next = StFinish;
                end else begin
                    w_state_next = StLaunch;
                    w_swap       = 1'b1;
                end
            end
            StFinish: w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_num_layers <= '0;
            r_layer_idx  <= '0;
            r_wdog       <= '0;
            r_rd_bank    <= 1'b0;
            r_wr_bank    <= 1'b1;
            r_eng_run    <= 1'b0;
            r_host_sel   <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_num_layers <= w_num_sat;
                r_layer_idx  <= '0;
                r_rd_bank    <= 1'b0;
                r_wr_bank    <= 1'b1;
            end else if (w_swap) begin
                r_layer_idx  <= r_layer_idx + LW'(1);
                r_rd_bank    <= ~r_rd_bank;
                r_wr_bank    <= ~r_wr_bank;
            end

            if (r_state == StLaunch) begin
                r_wdog <= '0;
            end else if (r_state == StRun) begin
                r_wdog <= r_wdog + WDW'(1);
            end

            if (w_accept || w_zero_start) begin
                r_err <= 1'b0;
            end else if (w_wd_expire) begin
                r_err <= 1'b1;
            end

            // Decode from the next state so the registered outputs track the state register.
            r_eng_run  <= (w_state_next == StRun);
            r_busy     <= (w_state_next != StIdle);
            r_host_sel <= (w_state_next == StIdle) || (w_state_next == StFinish);
            r_done     <= (w_state_next == StFinish) || w_zero_start;
        end
    end

    assign bus.eng_reset_n = r_eng_run;
    assign bus.rd_bank     = r_rd_bank;
    assign bus.wr_bank     = r_wr_bank;
    assign bus.layer_idx   = r_layer_idx;
    assign bus.host_sel    = r_host_sel;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.err         = r_err;
endmodule

// File: tb/tb_cnn_accel_layer_seq.sv
// Bench for cnn_accel_layer_seq: a job-level model (bank, layer index, error flag) plus an
// engine responder with random latencies, aborts, watchdog hangs and an async reset mid-job.
module tb_cnn_accel_layer_seq;
    localparam int unsigned MaxLayers = 8;
    localparam int unsigned Timeout   = 120;
    localparam int unsigned NW        = $clog2(MaxLayers + 1);

    logic clk = 1'b0;
    logic reset_n;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Job-level reference state: what the host should see between and within jobs.
    bit m_rd;
    int m_idx;
    bit m_err;

    cnn_accel_layer_seq_if #(.NUM_LAYERS_MAX(MaxLayers)) bus ();

    cnn_accel_layer_seq #(
        .NUM_LAYERS_MAX(MaxLayers),
        .WIDTH         (8),
        .HEIGHT        (4),
        .TIMEOUT_CYCLES(Timeout)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string pfx, input logic eng, input logic host,
                             input logic busy, input logic done);
        check({pfx, "_eng_reset_n"}, 32'(bus.eng_reset_n), 32'(eng));
        check({pfx, "_host_sel"},    32'(bus.host_sel),    32'(host));
        check({pfx, "_busy"},        32'(bus.busy),        32'(busy));
        check({pfx, "_done"},        32'(bus.done),        32'(done));
        check({pfx, "_err"},         32'(bus.err),         32'(m_err));
        check({pfx, "_rd_bank"},     32'(bus.rd_bank),     32'(m_rd));
        check({pfx, "_wr_bank"},     32'(bus.wr_bank),     32'(!m_rd));
        check({pfx, "_layer_idx"},   32'(bus.layer_idx),   32'(m_idx));
    endtask

    // abort_at / hang_at: layer index at which to abort (with eng_done) or never finish; -1 = none.
    task automatic run_job(input int n_req, input int abort_at, input int hang_at,
                           input int lat_fixed);
        int n;
        int lat;
        int t;
        n = (n_req > int'(MaxLayers)) ? int'(MaxLayers) : n_req;
        bus.start      = 1'b1;
        bus.num_layers = NW'(n_req);
        step();
        bus.start = 1'b0;
        m_err     = 1'b0;
        if (n == 0) begin
            check_all("zero", 1'b0, 1'b1, 1'b0, 1'b1);
            step();
            check_all("zero_after", 1'b0, 1'b1, 1'b0, 1'b0);
            return;
        end
        m_rd  = 1'b0;
        m_idx = 0;
        check_all("launch", 1'b0, 1'b0, 1'b1, 1'b0);
        bus.num_layers = NW'($urandom);
        for (int k = 0; k < n; k++) begin
            step();
            check_all("run", 1'b1, 1'b0, 1'b1, 1'b0);
            if (k == hang_at) begin
                t = 0;
                while (bus.eng_reset_n && t < int'(Timeout) + 4) begin
                    t++;
                    step();
                end
                check("wd_run_cycles", 32'(t), Timeout);
                m_err = 1'b1;
                check_all("wd_finish", 1'b0, 1'b1, 1'b1, 1'b1);
                step();
                check_all("wd_idle", 1'b0, 1'b1, 1'b0, 1'b0);
                return;
            end
            lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 40));
            for (int i = 1; i < lat; i++) begin
                bus.start = (i == lat / 2);
                step();
            end
            bus.start = 1'b0;
            check("run_hold", 32'(bus.eng_reset_n), 32'd1);
            bus.eng_done = 1'b1;
            bus.abort    = (k == abort_at);
            step();
            bus.eng_done = 1'b0;
            bus.abort    = 1'b0;
            if (k == abort_at) begin
                check_all("abort_finish", 1'b0, 1'b1, 1'b1, 1'b1);
                step();
                check_all("abort_idle", 1'b0, 1'b1, 1'b0, 1'b0);
                return;
            end
            check_all("drain", 1'b0, 1'b0, 1'b1, 1'b0);
            if (k < n - 1) begin
                step();
                check_all("swap", 1'b0, 1'b0, 1'b1, 1'b0);
                step();
                m_rd = !m_rd;
                m_idx++;
                check_all("relaunch", 1'b0, 1'b0, 1'b1, 1'b0);
            end else begin
                step();
                check_all("finish", 1'b0, 1'b1, 1'b1, 1'b1);
                check("final_wr_bank", 32'(bus.wr_bank), 32'(n % 2));
                step();
                check_all("idle", 1'b0, 1'b1, 1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        int n;
        int ab;
        reset_n        = 1'b0;
        bus.start      = 1'b0;
        bus.num_layers = '0;
        bus.abort      = 1'b0;
        bus.eng_done   = 1'b0;
        m_rd           = 1'b0;
        m_idx          = 0;
        m_err          = 1'b0;
        step();
        step();
        check_all("reset", 1'b0, 1'b1, 1'b0, 1'b0);
        reset_n = 1'b1;
        step();

        // abort and eng_done while idle have no effect
        bus.abort    = 1'b1;
        bus.eng_done = 1'b1;
        step();
        bus.abort    = 1'b0;
        bus.eng_done = 1'b0;
        check_all("idle_ignore", 1'b0, 1'b1, 1'b0, 1'b0);

        run_job(1, -1, -1, 100);
        run_job(3, -1, -1, 0);
        run_job(0, -1, -1, 0);
        run_job(3, -1, 1, 0);
        repeat (3) step();
        check_all("err_sticky", 1'b0, 1'b1, 1'b0, 1'b0);
        run_job(2, -1, -1, 0);
        run_job(4, 1, -1, 0);
        run_job(11, -1, -1, 0);

        for (int j = 0; j < 10; j++) begin
            n  = int'($urandom_range(0, 12));
            ab = ($urandom_range(0, 3) == 0 && n > 0)
                 ? int'($urandom_range(0, (n > 8 ? 8 : n) - 1)) : -1;
            run_job(n, ab, -1, 0);
        end

        // async reset in the middle of a running layer
        bus.start      = 1'b1;
        bus.num_layers = NW'(2);
        step();
        bus.start = 1'b0;
        step();
        step();
        check("pre_reset_run", 32'(bus.eng_reset_n), 32'd1);
        reset_n = 1'b0;
        #1;
        m_rd  = 1'b0;
        m_idx = 0;
        m_err = 1'b0;
        check_all("async_reset", 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) begin
            step();
            check("reset_no_done", 32'(bus.done), 32'd0);
        end
        reset_n = 1'b1;
        step();
        check_all("post_reset", 1'b0, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
